// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB write engine: FSM states, quarter-phase
// indices and default timing/addressing constants.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } sccb_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // 313 clk_25M cycles per quarter bit -> SCL of about 19.97 kHz.
  localparam int unsigned QTR_DIV_DEFAULT = 312;
  localparam int unsigned NBYTES_DEFAULT  = 4;
  localparam logic [7:0]  OV5640_WR_ADDR  = 8'h78;

endpackage

// File: rtl/sccb_write_master_if.sv
// Request/status handshake between the register-configuration sequencer
// (master side) and the SCCB write engine (slave side).
interface sccb_write_master_if;
  logic        start;
  logic [31:0] i2c_data;
  logic        busy;
  logic        tr_end;
  logic        nack;

  modport master (output start, output i2c_data, input busy, input tr_end, input nack);
  modport slave  (input start, input i2c_data, output busy, output tr_end, output nack);
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: counts 0..QTR_DIV while enabled and pulses
// qtick on the terminal count; parked at 0 while disabled.
module sccb_tick_gen #(
  parameter int unsigned QTR_DIV = 312
) (
  input  logic clk_25M,
  input  logic camera_rstn,
  input  logic en,
  output logic qtick
);
  localparam int unsigned W = (QTR_DIV > 0) ? $clog2(QTR_DIV + 1) : 1;
  localparam logic [W-1:0] TERM = W'(QTR_DIV);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn)           cnt <= '0;
    else if (!en || cnt == TERM) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign qtick = en && (cnt == TERM);
endmodule

// File: rtl/sccb_write_master.sv
// SCCB/I2C byte-level write engine for the OV5640. Define SCCB_ACK_CHECK_EN
// to report NACKs and abort the frame to STOP on the first one.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int unsigned QTR_DIV = QTR_DIV_DEFAULT,
  parameter int unsigned NBYTES  = NBYTES_DEFAULT
) (
  input  logic                clk_25M,
  input  logic                camera_rstn,
  sccb_write_master_if.slave  cfg,
  output logic                i2c_sclk,
  inout  wire                 i2c_sdat
);
  localparam int unsigned    BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  sccb_state_e    state_q, state_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [31:0]    shreg_q, shreg_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           busy, qtick, scl, sda_oe;

  assign busy = (state_q == START) || (state_q == BIT) ||
                (state_q == ACK)   || (state_q == STOP);

  sccb_tick_gen #(.QTR_DIV(QTR_DIV)) u_tick (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .en          (busy),
    .qtick       (qtick)
  );

`ifdef SCCB_ACK_CHECK_EN
  logic       nack_q, nack_d;
  logic [1:0] sda_sync;

  // NOTE: the pin synchroniser resets to 1 (released bus) so the first
  // sample after reset cannot read a phantom ACK.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      sda_sync <= 2'b11;
      nack_q   <= 1'b0;
    end else begin
      sda_sync <= {sda_sync[0], i2c_sdat};
      nack_q   <= nack_d;
    end
  end
  assign cfg.nack = nack_q;
`else
  assign cfg.nack = 1'b0;
`endif

  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q    <= IDLE;
      qtr_q      <= Q0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    qtr_d      = qtr_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    scl        = 1'b1;
    sda_oe     = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    nack_d     = nack_q;
`endif
    if (qtick) qtr_d = qtr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (cfg.start) begin
          state_d    = START;
          qtr_d      = Q0;
          shreg_d    = cfg.i2c_data;
          bit_cnt_d  = 3'd7;
          byte_cnt_d = '0;
`ifdef SCCB_ACK_CHECK_EN
          nack_d     = 1'b0;
`endif
        end
      end
      START: begin
        sda_oe = (qtr_q == Q2) || (qtr_q == Q3);
        scl    = (qtr_q != Q3);
        if (qtick && qtr_q == Q3) state_d = BIT;
      end
      BIT: begin
        // SDA is held for the whole unit so it only moves while SCL is low.
        scl    = qtr_q[1];
        sda_oe = !shreg_q[31];
        if (qtick && qtr_q == Q3) begin
          shreg_d = {shreg_q[30:0], 1'b0};
          if (bit_cnt_q == 3'd0) state_d = ACK;
          else                   bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      ACK: begin
        scl = qtr_q[1];
`ifdef SCCB_ACK_CHECK_EN
        if (qtick && qtr_q == Q1 && sda_sync[1]) nack_d = 1'b1;
`endif
        if (qtick && qtr_q == Q3) begin
          if (byte_cnt_q == LAST_BYTE) state_d = STOP;
`ifdef SCCB_ACK_CHECK_EN
          else if (nack_q)             state_d = STOP;
`endif
          else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            bit_cnt_d  = 3'd7;
            state_d    = BIT;
          end
        end
      end
      STOP: begin
        scl    = (qtr_q != Q0);
        sda_oe = (qtr_q != Q3);
        if (qtick && qtr_q == Q3) state_d = DONE;
      end
      DONE: begin
        if (!cfg.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg.busy   = busy;
  assign cfg.tr_end = (state_q == DONE);
  assign i2c_sclk   = scl;
  assign i2c_sdat   = sda_oe ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench for sccb_write_master: decodes the SCL/SDA bus with a
// protocol-level monitor/slave and compares frames against a frame model.
module tb_sccb_write_master;
  import sccb_pkg::*;

  localparam int QD   = 7;
  localparam int QLEN = QD + 1;
  localparam int NB   = 4;

  logic clk_25M     = 1'b0;
  logic camera_rstn = 1'b0;
  logic slave_drv   = 1'b0;
  wire  i2c_sclk;
  wire  i2c_sdat;

  always #20 clk_25M = ~clk_25M;

  sccb_write_master_if bus();

  pullup (i2c_sdat);
  assign i2c_sdat = slave_drv ? 1'b0 : 1'bz;

  sccb_write_master #(.QTR_DIV(QD), .NBYTES(NB)) dut (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .cfg         (bus.slave),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat    (i2c_sdat)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk_25M) cyc <= cyc + 1;

  // Bus monitor and ACKing slave: START/STOP are SDA edges while SCL is high;
  // a bit is taken at SCL rise and committed at the following SCL fall.
  logic       prev_scl = 1'b1, prev_sda = 1'b1, pend = 1'b0, pend_v = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] cur = '0;
  logic [7:0] rx[$];
  int         bitpos = 0, byte_in_frame = 0, bit_clocks = 0;
  int         n_start = 0, n_stop = 0;
  int unsigned start_ev_cyc = 0, stop_ev_cyc = 0;
  int         nack_byte = -1;

  always @(negedge clk_25M) begin
    logic scl_s, sda_s;
    scl_s = i2c_sclk;
    sda_s = i2c_sdat;
    if (!camera_rstn) begin
      in_frame = 1'b0; bitpos = 0; pend_v = 1'b0; slave_drv = 1'b0; byte_in_frame = 0;
    end else begin
      if (scl_s && prev_scl && sda_s != prev_sda) begin
        if (!sda_s) begin
          n_start++; start_ev_cyc = cyc;
          in_frame = 1'b1; bitpos = 0; pend_v = 1'b0; byte_in_frame = 0;
        end else begin
          n_stop++; stop_ev_cyc = cyc; in_frame = 1'b0;
        end
      end
      if (in_frame && scl_s && !prev_scl) begin
        pend = sda_s; pend_v = 1'b1;
      end
      if (in_frame && !scl_s && prev_scl && pend_v) begin
        pend_v = 1'b0;
        bit_clocks++;
        if (bitpos < 8) begin
          cur = {cur[6:0], pend};
          bitpos++;
          if (bitpos == 8) slave_drv = (byte_in_frame != nack_byte);
        end else begin
          rx.push_back(cur);
          bitpos = 0;
          byte_in_frame++;
          slave_drv = 1'b0;
        end
      end
    end
    prev_scl = scl_s;
    prev_sda = sda_s;
  end

  // Frame model: bytes that reach the bus and whether nack is reported.
  function automatic int model_nbytes(input int nb);
`ifdef SCCB_ACK_CHECK_EN
    if (nb >= 0 && nb < NB) return nb + 1;
`endif
    return NB;
  endfunction

  function automatic logic model_nack(input int nb);
`ifdef SCCB_ACK_CHECK_EN
    return (nb >= 0 && nb < NB);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [31:0] data;
    int          nb;
    int          hold;
    bit          drop;
    int          exp_nbytes;
    logic        exp_nack;
  } vec_t;

  task automatic pulse_reset();
    @(negedge clk_25M);
    camera_rstn = 1'b0;
    bus.start   = 1'b0;
    repeat (2) @(negedge clk_25M);
    camera_rstn = 1'b1;
    repeat (2) @(negedge clk_25M);
  endtask

  task automatic run_frame(input vec_t v);
    int unsigned c0, lat, exp_cycles, budget;
    int base_rx, base_bc, base_st, base_sp, units;
    logic [7:0] eb;
    bit all_high;
    nack_byte  = v.nb;
    units      = 2 + 9 * v.exp_nbytes;
    exp_cycles = units * 4 * QLEN;
    budget     = 2 * exp_cycles + 100;
    base_rx = rx.size(); base_bc = bit_clocks; base_st = n_start; base_sp = n_stop;

    @(negedge clk_25M);
    bus.i2c_data = v.data;
    bus.start    = 1'b1;
    c0 = cyc + 1;
    @(negedge clk_25M);
    while (!bus.tr_end && (cyc - c0) < budget) begin
      if (v.drop && (cyc - c0) == exp_cycles / 3) begin
        bus.start    = 1'b0;
        bus.i2c_data = $urandom;
      end
      if ((cyc - c0) == exp_cycles / 2) check("busy_mid", bus.busy, 1'b1);
      @(negedge clk_25M);
    end
    if (!bus.tr_end) begin
      check("tr_end_timeout", 1'b0, 1'b1);
      pulse_reset();
      return;
    end
    lat = cyc - c0;
    check("tr_end_latency", lat, exp_cycles);
    check("nbytes", rx.size() - base_rx, v.exp_nbytes);
    for (int i = 0; i < v.exp_nbytes && (base_rx + i) < rx.size(); i++) begin
      eb = 8'(v.data >> (24 - 8 * i));
      check($sformatf("byte%0d", i), rx[base_rx + i], eb);
    end
    check("scl_bit_clocks", bit_clocks - base_bc, 9 * v.exp_nbytes);
    check("start_count", n_start - base_st, 1);
    check("stop_count", n_stop - base_sp, 1);
    check("start_timing", start_ev_cyc - c0, 2 * QLEN);
    check("stop_timing", stop_ev_cyc - c0, (units * 4 - 1) * QLEN);
    check("nack", bus.nack, v.exp_nack);
    check("busy_done", bus.busy, 1'b0);

    if (v.drop) begin
      @(negedge clk_25M);
      check("tr_end_pulse", bus.tr_end, 1'b0);
    end else begin
      all_high = 1'b1;
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk_25M);
        all_high &= bus.tr_end && !bus.busy;
      end
      check("tr_end_held", all_high, 1'b1);
      check("no_restart", n_start - base_st, 1);
      bus.start = 1'b0;
      @(negedge clk_25M);
      check("tr_end_drop", bus.tr_end, 1'b0);
    end
    @(negedge clk_25M);
  endtask

  vec_t vecs[6];

  initial begin
    bus.start    = 1'b0;
    bus.i2c_data = '0;

    vecs[0] = '{32'h78310311, -1, 1000, 1'b0, 0, 1'b0};
    vecs[1] = '{32'h78300882, -1, 0,    1'b0, 0, 1'b0};
    vecs[2] = '{32'h78300882,  1, 3,    1'b0, 0, 1'b0};
    vecs[3] = '{{OV5640_WR_ADDR, 24'h000000}, -1, 0, 1'b1, 0, 1'b0};
    vecs[4] = '{32'h78FFFFFF,  3, 0,    1'b0, 0, 1'b0};
    vecs[5] = '{32'h78A55A00,  0, 0,    1'b1, 0, 1'b0};
    foreach (vecs[i]) begin
      vecs[i].exp_nbytes = model_nbytes(vecs[i].nb);
      vecs[i].exp_nack   = model_nack(vecs[i].nb);
    end

    repeat (3) @(negedge clk_25M);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_tr_end", bus.tr_end, 1'b0);
    check("rst_nack", bus.nack, 1'b0);
    check("rst_scl", i2c_sclk, 1'b1);
    check("rst_sda", i2c_sdat, 1'b1);
    camera_rstn = 1'b1;
    repeat (3) @(negedge clk_25M);
    check("idle_busy", bus.busy, 1'b0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset in the middle of byte 2: everything returns to idle at once.
    begin
      int base_rx, guard;
      nack_byte = -1;
      base_rx = rx.size();
      @(negedge clk_25M);
      bus.i2c_data = 32'h78123456;
      bus.start    = 1'b1;
      guard = 0;
      while (!(rx.size() - base_rx >= 2 && bitpos >= 3) && guard < 4000) begin
        @(negedge clk_25M);
        guard++;
      end
      check("reset_reach_byte2", guard < 4000, 1'b1);
      camera_rstn = 1'b0;
      #1;
      check("arst_scl", i2c_sclk, 1'b1);
      check("arst_sda", i2c_sdat, 1'b1);
      check("arst_busy", bus.busy, 1'b0);
      check("arst_tr_end", bus.tr_end, 1'b0);
      bus.start = 1'b0;
      repeat (2) @(negedge clk_25M);
      camera_rstn = 1'b1;
      repeat (3) @(negedge clk_25M);
      run_frame('{32'h78310311, -1, 2, 1'b0, NB, 1'b0});
    end

    for (int r = 0; r < 8; r++) begin
      vec_t v;
      int   sel;
      sel    = int'($urandom_range(0, 5));
      v.data = {OV5640_WR_ADDR, 24'($urandom)};
      v.nb   = (sel < NB) ? sel : -1;
      v.hold = int'($urandom_range(0, 6));
      v.drop = 1'($urandom_range(0, 1));
      v.exp_nbytes = model_nbytes(v.nb);
      v.exp_nack   = model_nack(v.nb);
      run_frame(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
